// File: rtl/bit_unpacker_if.sv
// bit_unpacker_if: stream-load and decode-request/result bundle for bit_unpacker
// Ports: master drives dataIn/dataIn_valid/endOfDataStream/decode_start/k_value;
// slave (the unpacker) drives dataIn_ready/busy and the dec_* result.
interface bit_unpacker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int K_WIDTH    = 4,
  parameter int QBPP       = 8,
  parameter int Q_WIDTH    = 6
);
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  dataIn_valid;
  logic                  dataIn_ready;
  logic                  endOfDataStream;
  logic                  decode_start;
  logic [K_WIDTH-1:0]    k_value;
  logic                  busy;
  logic                  dec_valid;
  logic [Q_WIDTH-1:0]    dec_unary;
  logic [QBPP-1:0]       dec_remainder;
  logic                  dec_escape;
  logic [7:0]            dec_length;
  logic                  dec_error;
  modport master (
    output dataIn, dataIn_valid, endOfDataStream, decode_start, k_value,
    input  dataIn_ready, busy, dec_valid, dec_unary, dec_remainder, dec_escape, dec_length, dec_error
  );
  modport slave (
    input  dataIn, dataIn_valid, endOfDataStream, decode_start, k_value,
    output dataIn_ready, busy, dec_valid, dec_unary, dec_remainder, dec_escape, dec_length, dec_error
  );
endinterface

// File: rtl/bit_unpacker.sv
// bit_unpacker: JPEG-LS Golomb/escape sample decoder over an MSB-first bit stream
// Ports: clk; reset (synchronous, active-low); bus (bit_unpacker_if.slave) carrying
// the stream input (dataIn/dataIn_valid/dataIn_ready/endOfDataStream), the decode
// request (decode_start/k_value), busy and the registered dec_* result.
// Option: define BIT_UNPACKER_BYTE_STUFFING_EN to drop the MSB of every byte after 0xFF.
module bit_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_WIDTH  = 64,
  parameter int K_WIDTH    = 4,
  parameter int QBPP       = 8,
  parameter int LIMIT      = 32,
  parameter int Q_WIDTH    = 6
) (
  input logic           clk,
  input logic           reset,
  bit_unpacker_if.slave bus
);
  localparam int CW   = $clog2(BUF_WIDTH + 1);
  localparam int KN   = 2 ** K_WIDTH;
  localparam int QMAX = LIMIT - QBPP;
  typedef enum logic [2:0] {IDLE, PREFIX, REMAIN, ESCAPE, DONE} state_t;
  state_t               r_state;
  logic [BUF_WIDTH-1:0] r_buf;
  logic [CW-1:0]        r_cnt;
  logic                 r_eos;
  logic [K_WIDTH-1:0]   r_k;
  logic [Q_WIDTH-1:0]   r_q;
  logic                 r_valid;
  logic                 r_esc;
  logic                 r_err;
  logic [Q_WIDTH-1:0]   r_unary;
  logic [QBPP-1:0]      r_rem;
  logic [7:0]           r_len;
  logic [DATA_WIDTH-1:0] w_pk;
  logic [CW-1:0]        w_ld;
  logic [CW-1:0]        w_need;
  logic [CW-1:0]        w_use;
  logic [CW-1:0]        w_left;
  logic [BUF_WIDTH-1:0] w_ext;
  logic [QBPP-1:0]      w_kbits;
  logic [7:0]           w_len;
  logic                 w_active;
  logic                 w_have;
  logic                 w_bit;
  logic                 w_load;
  logic                 w_under;
  logic                 w_over;
  logic                 w_fin;
`ifdef BIT_UNPACKER_BYTE_STUFFING_EN
  logic                  r_ff;
  logic [DATA_WIDTH+7:0] w_win;
  // top byte stands in for the last byte of the previous word
  assign w_win = {r_ff ? 8'hFF : 8'h00, bus.dataIn};
  always_comb begin
    int n;
    n = 0;
    w_pk = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++)
      for (int j = 7; j >= 0; j--)
        if (j != 7 || w_win[DATA_WIDTH + 7 - 8 * b -: 8] != 8'hFF) begin
          w_pk[DATA_WIDTH - 1 - n] = w_win[DATA_WIDTH - 8 - 8 * b + j];
          n++;
        end
    w_ld = CW'(n);
  end
  always_ff @(posedge clk)
    if (!reset) r_ff <= 1'b0;
    else if (w_load) r_ff <= bus.dataIn[7:0] == 8'hFF;
`else
  assign w_pk = bus.dataIn;
  assign w_ld = CW'(DATA_WIDTH);
`endif
  assign w_active = r_state == PREFIX || r_state == REMAIN || r_state == ESCAPE;
  assign w_need   = r_state == PREFIX ? CW'(1) : r_state == REMAIN ? CW'(r_k) : r_state == ESCAPE ? CW'(QBPP) : '0;
  assign w_have   = r_cnt >= w_need;
  assign w_use    = w_active && w_have ? w_need : '0;
  assign w_left   = r_cnt - w_use;
  assign w_bit    = r_buf[BUF_WIDTH-1];
  assign bus.dataIn_ready = reset && !r_eos && r_cnt <= CW'(BUF_WIDTH - DATA_WIDTH);
  assign w_load   = bus.dataIn_valid && bus.dataIn_ready;
  // new word lands directly below the bits that survive this cycle's consume
  assign w_ext    = BUF_WIDTH'(w_pk) << (BUF_WIDTH - DATA_WIDTH);
  // top k bits of the buffer, right-aligned (k = 0 gives 0)
  assign w_kbits  = QBPP'(({{KN{1'b0}}, r_buf[BUF_WIDTH-1 -: KN]} << r_k) >> KN);
  assign w_under  = w_active && !w_have && r_eos;
  assign w_over   = r_state == PREFIX && w_have && !w_bit && r_q == Q_WIDTH'(QMAX - 1);
  // k = 0 finishes on the terminating 1 itself unless it selects the escape path
  assign w_fin    = w_under || w_over
                 || (r_state == PREFIX && w_have && w_bit && r_k == '0 && r_q != Q_WIDTH'(QMAX - 1))
                 || ((r_state == REMAIN || r_state == ESCAPE) && w_have);
  // bits consumed by the sample, including those taken in this final cycle
  assign w_len    = 8'(r_q) + 8'(r_state != PREFIX || !w_under)
                  + (r_state == REMAIN && w_have ? 8'(r_k) : 8'd0)
                  + (r_state == ESCAPE && w_have ? 8'(QBPP) : 8'd0);
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_eos   <= 1'b0;
      r_k     <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
      r_unary <= '0;
      r_rem   <= '0;
      r_esc   <= 1'b0;
      r_err   <= 1'b0;
      r_len   <= '0;
    end else begin
      r_buf   <= (r_buf << w_use) | (w_load ? w_ext >> w_left : '0);
      r_cnt   <= w_left + (w_load ? w_ld : '0);
      r_eos   <= r_eos || (w_load && bus.endOfDataStream);
      r_valid <= w_fin;
      if (w_fin) begin
        r_state <= DONE;
        r_unary <= r_q + Q_WIDTH'(w_over);
        r_rem   <= !w_have ? '0 : r_state == ESCAPE ? r_buf[BUF_WIDTH-1 -: QBPP] : r_state == REMAIN ? w_kbits : '0;
        r_esc   <= r_state == ESCAPE && w_have;
        r_err   <= w_under || w_over;
        r_len   <= w_len;
      end else if (r_state == IDLE && bus.decode_start) begin
        r_state <= PREFIX;
        r_k     <= bus.k_value;
        r_q     <= '0;
      end else if (r_state == PREFIX && w_have) begin
        r_q     <= w_bit ? r_q : r_q + 1'b1;
        r_state <= !w_bit ? PREFIX : r_q == Q_WIDTH'(QMAX - 1) ? ESCAPE : REMAIN;
      end else if (r_state == DONE) begin
        r_state <= IDLE;
      end
    end
  end
  assign bus.busy          = r_state != IDLE;
  assign bus.dec_valid     = r_valid;
  assign bus.dec_unary     = r_unary;
  assign bus.dec_remainder = r_rem;
  assign bus.dec_escape    = r_esc;
  assign bus.dec_length    = r_len;
  assign bus.dec_error     = r_err;
endmodule

// File: tb/tb_bit_unpacker.sv
// tb_bit_unpacker: directed self-checking bench for bit_unpacker
module tb_bit_unpacker;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  bit_unpacker_if u_if ();
  bit_unpacker dut (.clk(clk), .reset(reset), .bus(u_if.slave));
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b0;
    u_if.dataIn_valid = 1'b0;
    u_if.endOfDataStream = 1'b0;
    u_if.decode_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_word(input logic [31:0] w, input logic eos);
    for (int i = 0; i < 50 && !u_if.dataIn_ready; i++) @(negedge clk);
    u_if.dataIn = w;
    u_if.dataIn_valid = 1'b1;
    u_if.endOfDataStream = eos;
    @(negedge clk);
    u_if.dataIn_valid = 1'b0;
    u_if.endOfDataStream = 1'b0;
  endtask

  task automatic run_decode(input logic [3:0] k, output logic seen, output int lat);
    for (int i = 0; i < 10 && u_if.busy; i++) @(negedge clk);
    u_if.k_value = k;
    u_if.decode_start = 1'b1;
    @(negedge clk);
    u_if.decode_start = 1'b0;
    lat = 1;
    while (!u_if.dec_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    seen = u_if.dec_valid;
  endtask

  task automatic test_reset();
    u_if.dataIn = '0;
    u_if.dataIn_valid = 1'b0;
    u_if.endOfDataStream = 1'b0;
    u_if.decode_start = 1'b0;
    u_if.k_value = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (u_if.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", u_if.busy); end
    tests++; if (u_if.dataIn_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", u_if.dataIn_ready); end
    tests++; if (u_if.dec_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", u_if.dec_valid); end
    tests++; if (u_if.dec_error !== 1'b0) begin fails++; $display("FAIL reset_error got %b exp 0", u_if.dec_error); end
    tests++; if (u_if.dec_length !== 8'd0) begin fails++; $display("FAIL reset_length got %0d exp 0", u_if.dec_length); end
    reset = 1'b1;
    @(negedge clk);
    tests++; if (u_if.dataIn_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b exp 1", u_if.dataIn_ready); end
  endtask

  task automatic test_normal();
    logic seen;
    int lat;
    apply_reset();
    load_word(32'h1800_0000, 1'b0);
    run_decode(4'd2, seen, lat);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL normal_valid got %b exp 1", seen); end
    tests++; if (lat != 6) begin fails++; $display("FAIL normal_latency got %0d exp 6", lat); end
    tests++; if (u_if.dec_unary !== 6'd3) begin fails++; $display("FAIL normal_unary got %0d exp 3", u_if.dec_unary); end
    tests++; if (u_if.dec_remainder !== 8'd2) begin fails++; $display("FAIL normal_rem got %0h exp 2", u_if.dec_remainder); end
    tests++; if (u_if.dec_length !== 8'd6) begin fails++; $display("FAIL normal_length got %0d exp 6", u_if.dec_length); end
    tests++; if (u_if.dec_escape !== 1'b0) begin fails++; $display("FAIL normal_escape got %b exp 0", u_if.dec_escape); end
    tests++; if (u_if.dec_error !== 1'b0) begin fails++; $display("FAIL normal_error got %b exp 0", u_if.dec_error); end
    @(negedge clk);
    tests++; if (u_if.dec_valid !== 1'b0) begin fails++; $display("FAIL normal_pulse got %b exp 0", u_if.dec_valid); end
    tests++; if (u_if.dec_unary !== 6'd3) begin fails++; $display("FAIL normal_hold got %0d exp 3", u_if.dec_unary); end
    tests++; if (u_if.busy !== 1'b0) begin fails++; $display("FAIL normal_idle_busy got %b exp 0", u_if.busy); end
  endtask

  task automatic test_escape();
    logic seen;
    int lat;
    apply_reset();
    load_word(32'h0000_014F, 1'b0);
    run_decode(4'd3, seen, lat);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL escape_valid got %b exp 1", seen); end
    tests++; if (lat != 26) begin fails++; $display("FAIL escape_latency got %0d exp 26", lat); end
    tests++; if (u_if.dec_escape !== 1'b1) begin fails++; $display("FAIL escape_flag got %b exp 1", u_if.dec_escape); end
    tests++; if (u_if.dec_unary !== 6'd23) begin fails++; $display("FAIL escape_unary got %0d exp 23", u_if.dec_unary); end
    tests++; if (u_if.dec_remainder !== 8'h4F) begin fails++; $display("FAIL escape_rem got %0h exp 4f", u_if.dec_remainder); end
    tests++; if (u_if.dec_length !== 8'd32) begin fails++; $display("FAIL escape_length got %0d exp 32", u_if.dec_length); end
    tests++; if (u_if.dec_error !== 1'b0) begin fails++; $display("FAIL escape_error got %b exp 0", u_if.dec_error); end
  endtask

  task automatic test_overrun();
    logic seen;
    int lat;
    apply_reset();
    load_word(32'h0000_00FF, 1'b0);
    run_decode(4'd4, seen, lat);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL overrun_valid got %b exp 1", seen); end
    tests++; if (lat != 25) begin fails++; $display("FAIL overrun_latency got %0d exp 25", lat); end
    tests++; if (u_if.dec_error !== 1'b1) begin fails++; $display("FAIL overrun_error got %b exp 1", u_if.dec_error); end
    tests++; if (u_if.dec_length !== 8'd24) begin fails++; $display("FAIL overrun_length got %0d exp 24", u_if.dec_length); end
    tests++; if (u_if.dec_escape !== 1'b0) begin fails++; $display("FAIL overrun_escape got %b exp 0", u_if.dec_escape); end
  endtask

  task automatic test_end_of_stream();
    logic seen;
    int lat;
    apply_reset();
    load_word(32'h8000_0000, 1'b1);
    tests++; if (u_if.dataIn_ready !== 1'b0) begin fails++; $display("FAIL eos_ready_after_load got %b exp 0", u_if.dataIn_ready); end
    run_decode(4'd0, seen, lat);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL eos_first_valid got %b exp 1", seen); end
    tests++; if (lat != 2) begin fails++; $display("FAIL eos_k0_latency got %0d exp 2", lat); end
    tests++; if (u_if.dec_unary !== 6'd0) begin fails++; $display("FAIL eos_first_unary got %0d exp 0", u_if.dec_unary); end
    tests++; if (u_if.dec_length !== 8'd1) begin fails++; $display("FAIL eos_first_length got %0d exp 1", u_if.dec_length); end
    tests++; if (u_if.dec_error !== 1'b0) begin fails++; $display("FAIL eos_first_error got %b exp 0", u_if.dec_error); end
    run_decode(4'd4, seen, lat);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL eos_second_valid got %b exp 1", seen); end
    tests++; if (u_if.dec_error !== 1'b1) begin fails++; $display("FAIL eos_second_error got %b exp 1", u_if.dec_error); end
    tests++; if (u_if.dec_length !== 8'd24) begin fails++; $display("FAIL eos_second_length got %0d exp 24", u_if.dec_length); end
    run_decode(4'd4, seen, lat);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL eos_third_valid got %b exp 1", seen); end
    tests++; if (u_if.dec_error !== 1'b1) begin fails++; $display("FAIL eos_third_error got %b exp 1", u_if.dec_error); end
    tests++; if (u_if.dec_length !== 8'd7) begin fails++; $display("FAIL eos_third_length got %0d exp 7", u_if.dec_length); end
    tests++; if (u_if.dataIn_ready !== 1'b0) begin fails++; $display("FAIL eos_ready_end got %b exp 0", u_if.dataIn_ready); end
  endtask

  task automatic test_back_to_back();
    logic seen;
    int lat;
    apply_reset();
    load_word(32'h0001_0000, 1'b0);
    load_word(32'h0F00_0000, 1'b0);
    run_decode(4'd4, seen, lat);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL b2b_first_valid got %b exp 1", seen); end
    tests++; if (lat != 18) begin fails++; $display("FAIL b2b_first_latency got %0d exp 18", lat); end
    tests++; if (u_if.dec_unary !== 6'd15) begin fails++; $display("FAIL b2b_first_unary got %0d exp 15", u_if.dec_unary); end
    tests++; if (u_if.dec_length !== 8'd20) begin fails++; $display("FAIL b2b_first_length got %0d exp 20", u_if.dec_length); end
    run_decode(4'd4, seen, lat);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL b2b_second_valid got %b exp 1", seen); end
    tests++; if (u_if.dec_unary !== 6'd16) begin fails++; $display("FAIL b2b_second_unary got %0d exp 16", u_if.dec_unary); end
    tests++; if (u_if.dec_remainder !== 8'd14) begin fails++; $display("FAIL b2b_second_rem got %0d exp 14", u_if.dec_remainder); end
    tests++; if (u_if.dec_length !== 8'd21) begin fails++; $display("FAIL b2b_second_length got %0d exp 21", u_if.dec_length); end
  endtask

`ifdef BIT_UNPACKER_BYTE_STUFFING_EN
  task automatic test_stuffing();
    logic seen;
    int lat;
    apply_reset();
    load_word(32'hFF7F_FFFF, 1'b0);
    load_word(32'h0000_0000, 1'b0);
    // the stuffed 0x7F MSB removed leaves a run of ones: every k=4 sample is 1 + 1111
    for (int i = 0; i < 6; i++) begin
      run_decode(4'd4, seen, lat);
      tests++; if (seen !== 1'b1 || u_if.dec_remainder !== 8'd15 || u_if.dec_length !== 8'd5) begin
        fails++; $display("FAIL stuff_sample%0d got rem %0d len %0d exp rem 15 len 5", i, u_if.dec_remainder, u_if.dec_length);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_prefix();
    logic seen;
    int lat;
    int strobes;
    apply_reset();
    load_word(32'h0000_0001, 1'b0);
    u_if.k_value = 4'd3;
    u_if.decode_start = 1'b1;
    @(negedge clk);
    u_if.decode_start = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (u_if.busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before got %b exp 1", u_if.busy); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (u_if.busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b exp 0", u_if.busy); end
    tests++; if (u_if.dataIn_ready !== 1'b0) begin fails++; $display("FAIL mid_ready got %b exp 0", u_if.dataIn_ready); end
    tests++; if (u_if.dec_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b exp 0", u_if.dec_valid); end
    reset = 1'b1;
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.dec_valid) strobes++;
    end
    tests++; if (strobes != 0) begin fails++; $display("FAIL mid_no_strobe got %0d exp 0", strobes); end
    load_word(32'h5800_0000, 1'b0);
    run_decode(4'd3, seen, lat);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL mid_fresh_valid got %b exp 1", seen); end
    tests++; if (lat != 4) begin fails++; $display("FAIL mid_fresh_latency got %0d exp 4", lat); end
    tests++; if (u_if.dec_unary !== 6'd1) begin fails++; $display("FAIL mid_fresh_unary got %0d exp 1", u_if.dec_unary); end
    tests++; if (u_if.dec_remainder !== 8'd3) begin fails++; $display("FAIL mid_fresh_rem got %0d exp 3", u_if.dec_remainder); end
    tests++; if (u_if.dec_length !== 8'd5) begin fails++; $display("FAIL mid_fresh_length got %0d exp 5", u_if.dec_length); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_escape();
    test_overrun();
    test_end_of_stream();
    test_back_to_back();
`ifdef BIT_UNPACKER_BYTE_STUFFING_EN
    test_stuffing();
`endif
    test_reset_mid_prefix();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
